// File: rtl/mdu_seq.sv
// Multiply/divide sequencer for the Execute stage: latches operands, counts a fixed
// latency, owns HI/LO and raises the Decode-stage stall for HI/LO hazards.
module mdu_seq #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cancel,
    input  logic        d_md_use,
    output logic        busy,
    output logic        stall,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      op_q, op_d;
    logic [31:0]     a_q, a_d, b_q, b_d;
    logic [31:0]     hi_q, hi_d, lo_q, lo_d;
    logic            done_q, done_d;

    logic            accept;
    logic            long_op;
    logic            res_wr;
    logic [31:0]     res_hi, res_lo;
    logic [63:0]     prod_s, prod_u;
    logic signed [31:0] sa, sb, squot, srem;

    assign long_op = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    assign accept  = start && !cancel && (state_q == IDLE);

    assign busy  = (state_q == RUN);
    assign stall = d_md_use && (busy || (start && !cancel && long_op));
    assign done  = done_q;
    assign hi    = hi_q;
    assign lo    = lo_q;

    // Result datapath works only from latched operands.
    always_comb begin
        sa     = $signed(a_q);
        sb     = $signed(b_q);
        prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
        prod_u = {32'b0, a_q} * {32'b0, b_q};
        squot  = 32'sd0;
        srem   = 32'sd0;
        if (b_q != 32'd0 && !(a_q == 32'h8000_0000 && b_q == 32'hFFFF_FFFF)) begin
            squot = sa / sb;
            srem  = sa % sb;
        end
    end

    always_comb begin
        res_wr = 1'b0;
        res_hi = hi_q;
        res_lo = lo_q;
        case (op_q)
            OP_MULT: begin
                res_wr = 1'b1;
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
            end
            OP_MULTU: begin
                res_wr = 1'b1;
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
            end
            OP_DIV: begin
                if (b_q == 32'd0) begin
                    res_wr = 1'b0;
                end else if (a_q == 32'h8000_0000 && b_q == 32'hFFFF_FFFF) begin
                    // Quotient overflows; wraps to the dividend, remainder is zero.
                    res_wr = 1'b1;
                    res_hi = 32'd0;
                    res_lo = 32'h8000_0000;
                end else begin
                    res_wr = 1'b1;
                    res_hi = srem;
                    res_lo = squot;
                end
            end
            OP_DIVU: begin
                if (b_q != 32'd0) begin
                    res_wr = 1'b1;
                    res_hi = a_q % b_q;
                    res_lo = a_q / b_q;
                end
            end
            default: res_wr = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (long_op) begin
                        state_d = RUN;
                        op_d    = op;
                        a_d     = a;
                        b_d     = b;
                        cnt_d   = (op == OP_MULT || op == OP_MULTU) ? CW'(MULT_CYCLES - 1)
                                                                    : CW'(DIV_CYCLES - 1);
                    end else if (op == OP_MTHI) begin
                        hi_d = a;
                    end else if (op == OP_MTLO) begin
                        lo_d = a;
                    end
                end
            end
            RUN: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    if (res_wr) begin
                        hi_d = res_hi;
                        lo_d = res_lo;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end
endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against an arithmetic model.
module tb_mdu_seq;
    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, cancel, d_md_use;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        busy, stall, done;
    logic [31:0] hi, lo;

    int n_vec = 0;
    int n_bad = 0;

    // Behavioural model state
    int          m_busy_left = 0;
    logic        m_done = 1'b0;
    logic [31:0] m_hi = '0, m_lo = '0;
    logic        m_pwr = 1'b0;
    logic [31:0] m_phi = '0, m_plo = '0;

    mdu_seq #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .cancel(cancel), .d_md_use(d_md_use), .busy(busy), .stall(stall),
        .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Pure arithmetic view of what each long operation leaves in HI/LO.
    task automatic compute(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                           output logic wr, output logic [31:0] rh, output logic [31:0] rl);
        longint          sx, sy, q, r;
        longint unsigned ux, uy, p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'({32'b0, x});
        uy = longint'({32'b0, y});
        wr = 1'b1;
        rh = '0;
        rl = '0;
        case (o)
            3'd1: begin p = longint'(sx * sy); rh = p[63:32]; rl = p[31:0]; end
            3'd2: begin p = ux * uy;           rh = p[63:32]; rl = p[31:0]; end
            3'd3: begin
                if (y == 0) wr = 1'b0;
                else begin q = sx / sy; r = sx % sy; rl = q[31:0]; rh = r[31:0]; end
            end
            3'd4: begin
                if (y == 0) wr = 1'b0;
                else begin p = ux / uy; rl = p[31:0]; p = ux % uy; rh = p[31:0]; end
            end
            default: wr = 1'b0;
        endcase
    endtask

    always @(posedge clk) begin
        if (!reset) begin
            m_done = 1'b0;
            if (m_busy_left > 0) begin
                m_busy_left--;
                if (m_busy_left == 0) begin
                    if (m_pwr) begin m_hi = m_phi; m_lo = m_plo; end
                    m_done = 1'b1;
                end
            end else if (start && !cancel) begin
                case (op)
                    3'd1, 3'd2: begin compute(op, a, b, m_pwr, m_phi, m_plo); m_busy_left = MC; end
                    3'd3, 3'd4: begin compute(op, a, b, m_pwr, m_phi, m_plo); m_busy_left = DC; end
                    3'd5: m_hi = a;
                    3'd6: m_lo = a;
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            logic exp_stall;
            exp_stall = d_md_use && (m_busy_left > 0 ||
                        (start && !cancel && op >= 3'd1 && op <= 3'd4));
            chk("busy", {31'b0, busy}, {31'b0, m_busy_left > 0});
            chk("done", {31'b0, done}, {31'b0, m_done});
            chk("stall", {31'b0, stall}, {31'b0, exp_stall});
            chk("hi", hi, m_hi);
            chk("lo", lo, m_lo);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic c, input logic use_d);
        start = 1'b1; op = o; a = x; b = y; cancel = c; d_md_use = use_d;
        tick();
        start = 1'b0; cancel = 1'b0; op = 3'd0;
        a = $urandom; b = $urandom;
    endtask

    task automatic wait_done();
        int n = 0;
        while (m_busy_left > 0 && n < 40) begin tick(); n++; end
        if (n >= 40) begin
            n_vec++; n_bad++;
            $display("FAIL wait_done: busy_left=%0d expected 0 within 40 cycles", m_busy_left);
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom % 6)
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom % 8);
            default: return 32'($urandom);
        endcase
    endfunction

    task automatic async_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        m_busy_left = 0; m_done = 1'b0; m_hi = '0; m_lo = '0;
        #1 reset = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; cancel = 1'b0; d_md_use = 1'b0;
        op = 3'd0; a = '0; b = '0;
        tick(); tick();
        chk("init_busy", {31'b0, busy}, 32'd0);
        chk("init_hi", hi, 32'd0);
        chk("init_lo", lo, 32'd0);
        reset = 1'b0;
        tick();

        issue(3'd1, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0);
        wait_done();
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFF1);
        tick();

        issue(3'd4, 32'd7, 32'd2, 1'b0, 1'b1);
        wait_done();
        chk("divu_hi", hi, 32'd1);
        chk("divu_lo", lo, 32'd3);
        tick();
        d_md_use = 1'b0;

        issue(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        wait_done();
        chk("div_hi", hi, 32'hFFFF_FFFF);
        chk("div_lo", lo, 32'hFFFF_FFFD);
        tick();

        issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        wait_done();
        chk("ovf_hi", hi, 32'd0);
        chk("ovf_lo", lo, 32'h8000_0000);
        tick();

        issue(3'd4, 32'd99, 32'd0, 1'b0, 1'b0);
        wait_done();
        chk("dz_hi", hi, 32'd0);
        chk("dz_lo", lo, 32'h8000_0000);
        tick();

        issue(3'd1, 32'd3, 32'd4, 1'b1, 1'b1);
        chk("cancel_busy", {31'b0, busy}, 32'd0);
        d_md_use = 1'b0;
        tick();

        issue(3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
        tick();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        wait_done();
        chk("runcan_hi", hi, 32'd1);
        chk("runcan_lo", lo, 32'hFFFF_FFFE);
        tick();

        issue(3'd6, 32'h1234, 32'd0, 1'b0, 1'b0);
        chk("mtlo_lo", lo, 32'h1234);
        issue(3'd5, 32'hDEAD_BEEF, 32'd0, 1'b1, 1'b0);
        chk("mthi_can", hi, 32'd1);
        tick();

        issue(3'd3, 32'd100, 32'd7, 1'b0, 1'b0);
        tick(); tick(); tick();
        async_reset();
        tick(); tick();
        issue(3'd1, 32'd6, 32'd7, 1'b0, 1'b0);
        wait_done();
        chk("post_rst_lo", lo, 32'd42);
        chk("post_rst_hi", hi, 32'd0);
        tick();

        for (int i = 0; i < 600; i++) begin
            d_md_use = 1'($urandom % 2);
            cancel   = ($urandom % 5) == 0;
            if (m_busy_left == 0 && ($urandom % 3) == 0) begin
                start = 1'b1;
                op    = 3'($urandom % 8);
                a     = pick();
                b     = pick();
            end else begin
                start = 1'b0;
                op    = 3'($urandom % 8);
                a     = $urandom;
                b     = $urandom;
            end
            tick();
        end
        start = 1'b0; cancel = 1'b0;
        wait_done();
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
